// File: rtl/chnl_tx_pkg.sv
// Shared CHNL package: FSM state codes for the rx/tx channel engines.
// Also holds a helper computing beats per transaction.
package chnl_tx_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    localparam logic [1:0] S_RX_IDLE = 2'd0;
    localparam logic [1:0] S_RX_RECV = 2'd1;

    function automatic int unsigned beats_per_txn(
        input int unsigned len,
        input int unsigned width
    );
        return len / (width / 32);
    endfunction

endpackage

// File: rtl/chnl_tx_if.sv
// Valid/ready input stream into chnl_tx.
// Ports: i_val/i_data from the source, i_rdy back to it.
interface chnl_tx_if #(
    parameter int W = 32
) ();
    logic         i_val;
    logic         i_rdy;
    logic [W-1:0] i_data;

    modport master (output i_val, output i_data, input  i_rdy);
    modport slave  (input  i_val, input  i_data, output i_rdy);
endinterface

// File: rtl/chnl_tx_buffer.sv
// One-entry pipeline buffer with full-throughput pass-through.
// Ports: clk/rst, i_val/i_rdy/i_data in, o_val/o_rdy/o_data out.
module chnl_tx_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_val,
    output logic             i_rdy,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_val,
    input  logic             o_rdy,
    output logic [WIDTH-1:0] o_data
);
    logic full;

    assign i_rdy = !full || o_rdy;
    assign o_val = full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full   <= 1'b0;
            o_data <= '0;
        end else if (i_val && i_rdy) begin
            full   <= 1'b1;
            o_data <= i_data;
        end else if (o_rdy) begin
            full   <= 1'b0;
        end
    end

endmodule

// File: rtl/chnl_tx_repacker.sv
// Width repacker: IN slices of W bits in, OUT slices out, lowest first.
// Ports: clk/rst, i_val/i_rdy/i_data in, o_val/o_rdy/o_data out.
module chnl_tx_repacker #(
    parameter int IN  = 1,
    parameter int OUT = 1,
    parameter int W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_val,
    output logic              i_rdy,
    input  logic [IN*W-1:0]   i_data,
    output logic              o_val,
    input  logic              o_rdy,
    output logic [OUT*W-1:0]  o_data
);
    localparam int CAP = IN + OUT;
    localparam int CW  = $clog2(CAP + 1);

    logic [CAP*W-1:0] sr, sr_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             pop, push;

    // i_rdy depends on fill level only, so no path from o_rdy.
    assign i_rdy  = (cnt <= CW'(OUT));
    assign o_val  = (cnt >= CW'(OUT));
    assign o_data = sr[OUT*W-1:0];
    assign pop    = o_val & o_rdy;
    assign push   = i_val & i_rdy;

    always_comb begin
        sr_nxt  = sr;
        cnt_nxt = cnt;
        if (pop) begin
            sr_nxt  = sr >> (OUT * W);
            cnt_nxt = cnt - CW'(OUT);
        end
        if (push) begin
            for (int i = 0; i < CAP; i++) begin
                if (i >= int'(cnt_nxt) && i < int'(cnt_nxt) + IN) begin
                    sr_nxt[i*W +: W] = i_data[(i - int'(cnt_nxt))*W +: W];
                end
            end
            cnt_nxt = cnt_nxt + CW'(IN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            sr  <= sr_nxt;
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/chnl_tx.sv
// Riffa CHNL transmitter: repacks a word stream into fixed-length TX txns.
// Ports: clk/rst, in_if stream, CHNL_TX_* host channel signals.
module chnl_tx
    import chnl_tx_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int TX_WIDTH         = 32,
    parameter int GCD              = 32,
    parameter int TX_LEN           = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    chnl_tx_if.slave                    in_if,
    output logic                        CHNL_TX_CLK,
    output logic                        CHNL_TX,
    input  logic                        CHNL_TX_ACK,
    output logic                        CHNL_TX_LAST,
    output logic [31:0]                 CHNL_TX_LEN,
    output logic [30:0]                 CHNL_TX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
    output logic                        CHNL_TX_DATA_VALID,
    input  logic                        CHNL_TX_DATA_REN
);
    localparam int IN  = TX_WIDTH / GCD;
    localparam int OUT = C_PCI_DATA_WIDTH / GCD;
    localparam logic [31:0] BEATS =
        32'(beats_per_txn(TX_LEN, C_PCI_DATA_WIDTH));

    logic                        rp_o_val, rp_o_rdy;
    logic [C_PCI_DATA_WIDTH-1:0] rp_o_data;
    logic                        bf_o_val, bf_o_rdy;
    logic [1:0]                  state;
    logic [31:0]                 cnt_left;
    logic                        in_send;

    chnl_tx_repacker #(
        .IN  (IN),
        .OUT (OUT),
        .W   (GCD)
    ) u_repack (
        .clk    (clk),
        .rst    (rst),
        .i_val  (in_if.i_val),
        .i_rdy  (in_if.i_rdy),
        .i_data (in_if.i_data),
        .o_val  (rp_o_val),
        .o_rdy  (rp_o_rdy),
        .o_data (rp_o_data)
    );

    chnl_tx_buffer #(
        .WIDTH (C_PCI_DATA_WIDTH)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .i_val  (rp_o_val),
        .i_rdy  (rp_o_rdy),
        .i_data (rp_o_data),
        .o_val  (bf_o_val),
        .o_rdy  (bf_o_rdy),
        .o_data (CHNL_TX_DATA)
    );

    assign CHNL_TX_CLK  = clk;
    assign CHNL_TX_LAST = 1'b1;
    assign CHNL_TX_LEN  = 32'(TX_LEN);
    assign CHNL_TX_OFF  = '0;

    // Beats are only ever exposed in S_SEND; the host's REN drives the
    // buffer's pop only there, so REN in other states has no effect.
    assign in_send            = (state == S_SEND);
    assign CHNL_TX            = (state == S_REQ) || in_send;
    assign CHNL_TX_DATA_VALID = in_send && bf_o_val;
    assign bf_o_rdy           = in_send && CHNL_TX_DATA_REN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt_left <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bf_o_val) state <= S_REQ;
                end
                S_REQ: begin
                    if (CHNL_TX_ACK) begin
                        cnt_left <= BEATS;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN) begin
                        cnt_left <= cnt_left - 32'd1;
                        if (cnt_left == 32'd1) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
